// File: rtl/vx_wb_pkg.sv
// Shared definitions for the M/W write-back drain: write-back select codes
// and the layout of one buffered register-file write.
package vx_wb_pkg;

    localparam logic [1:0] WB_NONE = 2'd0;
    localparam logic [1:0] WB_ALU  = 2'd1;
    localparam logic [1:0] WB_MEM  = 2'd2;
    localparam logic [1:0] WB_PC   = 2'd3;

    // Widths the entry layout is built for; the drain's parameters must match.
    localparam int VX_NUM_THREADS = 4;
    localparam int VX_WARP_W      = 3;

    // One pending register-file write; data is already lane-selected.
    typedef struct packed {
        logic [4:0]                  rd;
        logic [VX_NUM_THREADS-1:0]   mask;
        logic [VX_WARP_W-1:0]        warp;
        logic [VX_NUM_THREADS*32-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/vx_wb_fifo.sv
// Generic synchronous FIFO, synchronous active-low reset. DEPTH need not be
// a power of two: pointers wrap with an explicit compare against DEPTH-1.
module vx_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy, with modulo-DEPTH wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vx_wb_drain.sv
// Receiving end of the M/W pipeline register. Selects write-back data,
// drops entries that write nothing, buffers the rest and drives the
// register-file write port. Optional perf counters: VX_WB_DRAIN_PERF_EN.
module vx_wb_drain
    import vx_wb_pkg::*;
#(
    parameter int NUM_THREADS = VX_NUM_THREADS,
    parameter int WARP_W      = VX_WARP_W,
    parameter int DEPTH       = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_THREADS*32-1:0] in_alu_result,
    input  logic [NUM_THREADS*32-1:0] in_mem_result,
    input  logic [4:0]                in_rd,
    input  logic [1:0]                in_wb,
    input  logic [31:0]               in_PC_next,
    input  logic [NUM_THREADS-1:0]    in_valid,
    input  logic [WARP_W-1:0]         in_warp_num,
    output logic                      out_freeze,
    output logic                      rf_wr_en,
    output logic [4:0]                rf_wr_rd,
    output logic [NUM_THREADS-1:0]    rf_wr_mask,
    output logic [WARP_W-1:0]         rf_wr_warp,
    output logic [NUM_THREADS*32-1:0] rf_wr_data,
    input  logic                      rf_ready
`ifdef VX_WB_DRAIN_PERF_EN
   ,output logic [31:0]               perf_stall_cycles,
    output logic [31:0]               perf_writes
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    // The entry layout lives in the package, so the widths must agree.
    if (NUM_THREADS != VX_NUM_THREADS || WARP_W != VX_WARP_W) begin : g_width_check
        $error("vx_wb_drain: NUM_THREADS/WARP_W must match vx_wb_pkg");
    end
    if (DEPTH < 2 || DEPTH > 8) begin : g_depth_check
        $error("vx_wb_drain: DEPTH must be within 2..8");
    end

    wb_entry_t        push_entry;
    wb_entry_t        head_entry;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             push;
    logic             pop;

    // Freeze comes only from registered occupancy; rf_ready never reaches it.
    assign out_freeze = fifo_full;
    assign accept     = !fifo_full;
    assign push       = accept && (in_wb != WB_NONE) && (in_rd != 5'd0) && (in_valid != '0);
    assign rf_wr_en   = (fifo_count != '0);
    assign pop        = rf_wr_en && rf_ready;

    // Lane select happens before buffering so the FIFO holds final data.
    always_comb begin
        push_entry      = '0;
        push_entry.rd   = in_rd;
        push_entry.mask = in_valid;
        push_entry.warp = in_warp_num;
        for (int t = 0; t < NUM_THREADS; t++) begin
            case (in_wb)
                WB_ALU:  push_entry.data[t*32 +: 32] = in_alu_result[t*32 +: 32];
                WB_MEM:  push_entry.data[t*32 +: 32] = in_mem_result[t*32 +: 32];
                WB_PC:   push_entry.data[t*32 +: 32] = in_PC_next;
                default: push_entry.data[t*32 +: 32] = 32'd0;
            endcase
        end
    end

    vx_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(wb_entry_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wr_data (push_entry),
        .pop     (pop),
        .rd_data (head_entry),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Write port shows the head entry, forced to zero while nothing is buffered.
    always_comb begin
        rf_wr_rd   = '0;
        rf_wr_mask = '0;
        rf_wr_warp = '0;
        rf_wr_data = '0;
        if (!fifo_empty) begin
            rf_wr_rd   = head_entry.rd;
            rf_wr_mask = head_entry.mask;
            rf_wr_warp = head_entry.warp;
            rf_wr_data = head_entry.data;
        end
    end

`ifdef VX_WB_DRAIN_PERF_EN
    // Saturating counters for stalled-write cycles and completed writes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_stall_cycles <= '0;
            perf_writes       <= '0;
        end else begin
            if (rf_wr_en && !rf_ready && perf_stall_cycles != 32'hFFFF_FFFF) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (pop && perf_writes != 32'hFFFF_FFFF) begin
                perf_writes <= perf_writes + 32'd1;
            end
        end
    end
`endif

endmodule
